// File: rtl/sram_alloc_arbiter_pkg.sv
// Shared sizing constants, port FSM encoding and page-count helper for the SRAM allocation arbiter.
package sram_alloc_arbiter_pkg;

   localparam int NUM_PORTS  = 16;
   localparam int NUM_SRAMS  = 32;
   localparam int SRAM_IDX_W = 5;
   localparam int PAGE_CNT_W = 11;
   localparam int LEN_W      = 6;
   localparam int PORT_IDX_W = $clog2(NUM_PORTS);
   localparam int WAIT_CNT_W = 8;

   typedef logic [1:0] port_state_t;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_WAIT  = 2'd1;
   localparam logic [1:0] ST_BOUND = 2'd2;

   // Header carries length minus one; the SRAM must hold length pages.
   function automatic logic [PAGE_CNT_W-1:0] pages_needed(input logic [LEN_W-1:0] len);
      return PAGE_CNT_W'(len) + PAGE_CNT_W'(1);
   endfunction

endpackage

// File: rtl/sram_alloc_arbiter_max_free_sel.sv
// Combinational selector: eligible SRAM with the largest free page count, lowest index on ties.
module sram_alloc_arbiter_max_free_sel
   import sram_alloc_arbiter_pkg::*;
(
   input  logic [NUM_SRAMS*PAGE_CNT_W-1:0] free_space_i,
   input  logic [NUM_SRAMS-1:0]            elig_i,
   output logic                            found_o,
   output logic [SRAM_IDX_W-1:0]           idx_o
);

   // Heap-ordered comparator tree: node k merges children 2k (lower indices) and 2k+1.
   always_comb begin
      logic                  vld [2*NUM_SRAMS];
      logic [PAGE_CNT_W-1:0] val [2*NUM_SRAMS];
      logic [SRAM_IDX_W-1:0] idx [2*NUM_SRAMS];
      logic                  pick_hi;
      pick_hi = 1'b0;
      vld[0]  = 1'b0;
      val[0]  = '0;
      idx[0]  = '0;
      for (int s = 0; s < NUM_SRAMS; s++) begin
         vld[NUM_SRAMS+s] = elig_i[s];
         val[NUM_SRAMS+s] = free_space_i[s*PAGE_CNT_W +: PAGE_CNT_W];
         idx[NUM_SRAMS+s] = SRAM_IDX_W'(s);
      end
      for (int k = NUM_SRAMS-1; k >= 1; k--) begin
         pick_hi = vld[2*k+1] && (!vld[2*k] || (val[2*k+1] > val[2*k]));
         vld[k]  = vld[2*k] || vld[2*k+1];
         val[k]  = pick_hi ? val[2*k+1] : val[2*k];
         idx[k]  = pick_hi ? idx[2*k+1] : idx[2*k];
      end
      found_o = vld[1];
      idx_o   = idx[1];
   end

endmodule

// File: rtl/sram_alloc_arbiter.sv
// Write-side SRAM allocation arbiter: one grant per cycle, exclusive SRAM binding until end-of-packet.
// Build option ALLOC_TIMEOUT_EN adds a per-port 8-bit wait timeout that pulses grant_fail_o.
//
//   state    | meaning
//   ST_IDLE  | no packet pending
//   ST_WAIT  | packet pending, competing for an SRAM
//   ST_BOUND | SRAM bound to this port until release
module sram_alloc_arbiter
   import sram_alloc_arbiter_pkg::*;
(
   input  logic                            clk_i,
   input  logic                            rst_i,
   input  logic [NUM_PORTS-1:0]            req_vld_i,
   input  logic [NUM_PORTS*LEN_W-1:0]      req_len_i,
   input  logic [NUM_PORTS-1:0]            release_i,
   input  logic [NUM_SRAMS*PAGE_CNT_W-1:0] free_space_i,
   output logic [NUM_PORTS-1:0]            grant_vld_o,
   output logic [NUM_PORTS*SRAM_IDX_W-1:0] grant_sram_o,
   output logic [NUM_SRAMS-1:0]            sram_bound_o,
   output logic [NUM_PORTS-1:0]            grant_fail_o
);

   port_state_t           state_q [NUM_PORTS];
   port_state_t           state_d [NUM_PORTS];
   logic [SRAM_IDX_W-1:0] bind_q  [NUM_PORTS];
   logic [SRAM_IDX_W-1:0] bind_d  [NUM_PORTS];
   logic [NUM_SRAMS-1:0]  bound_q, bound_d;
   logic [PORT_IDX_W-1:0] rr_q, rr_d;
   logic [NUM_PORTS-1:0]  gvld_q, gvld_d;

   logic [NUM_PORTS-1:0]  cand;
   logic                  sel_found;
   logic [PORT_IDX_W-1:0] sel_port;
   logic [PAGE_CNT_W-1:0] need;
   logic [NUM_SRAMS-1:0]  elig;
   logic                  sram_found;
   logic [SRAM_IDX_W-1:0] sram_idx;
   logic                  grant;

`ifdef ALLOC_TIMEOUT_EN
   logic [WAIT_CNT_W-1:0] cnt_q [NUM_PORTS];
   logic [WAIT_CNT_W-1:0] cnt_d [NUM_PORTS];
   logic [NUM_PORTS-1:0]  fail_q, fail_d;
`endif

   // A port withdrawing or aborting this cycle is not a contender.
   always_comb begin
      cand = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         cand[p] = (state_q[p] == ST_WAIT) && req_vld_i[p] && !release_i[p];
      end
   end

   always_comb begin
      logic [PORT_IDX_W-1:0] pi;
      pi        = '0;
      sel_found = 1'b0;
      sel_port  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         pi = rr_q + PORT_IDX_W'(i);
         if (!sel_found && cand[pi]) begin
            sel_found = 1'b1;
            sel_port  = pi;
         end
      end
   end

   always_comb begin
      need = pages_needed(req_len_i[sel_port*LEN_W +: LEN_W]);
      elig = '0;
      for (int s = 0; s < NUM_SRAMS; s++) begin
         elig[s] = !bound_q[s] && (free_space_i[s*PAGE_CNT_W +: PAGE_CNT_W] >= need);
      end
   end

   sram_alloc_arbiter_max_free_sel u_max_free_sel (
      .free_space_i (free_space_i),
      .elig_i       (elig),
      .found_o      (sram_found),
      .idx_o        (sram_idx)
   );

   // Only the round-robin winner is considered; a miss stalls the pointer on that port.
   assign grant = sel_found && sram_found;
   assign rr_d  = grant ? (sel_port + PORT_IDX_W'(1)) : rr_q;

   always_comb begin
      bound_d = bound_q;
      gvld_d  = '0;
`ifdef ALLOC_TIMEOUT_EN
      fail_d  = '0;
`endif
      for (int p = 0; p < NUM_PORTS; p++) begin
         state_d[p] = state_q[p];
         bind_d[p]  = bind_q[p];
`ifdef ALLOC_TIMEOUT_EN
         cnt_d[p]   = cnt_q[p];
`endif
         case (state_q[p])
            ST_IDLE: begin
               if (req_vld_i[p]) begin
                  state_d[p] = ST_WAIT;
`ifdef ALLOC_TIMEOUT_EN
                  cnt_d[p]   = '0;
`endif
               end
            end
            ST_WAIT: begin
               if (!req_vld_i[p] || release_i[p]) begin
                  state_d[p] = ST_IDLE;
               end else if (grant && (sel_port == PORT_IDX_W'(p))) begin
                  state_d[p] = ST_BOUND;
                  bind_d[p]  = sram_idx;
                  gvld_d[p]  = 1'b1;
               end
`ifdef ALLOC_TIMEOUT_EN
               else if (cnt_q[p] == {WAIT_CNT_W{1'b1}}) begin
                  state_d[p] = ST_IDLE;
                  fail_d[p]  = 1'b1;
               end else begin
                  cnt_d[p] = cnt_q[p] + WAIT_CNT_W'(1);
               end
`endif
            end
            ST_BOUND: begin
               if (release_i[p]) begin
                  state_d[p]          = ST_IDLE;
                  bind_d[p]           = '0;
                  bound_d[bind_q[p]]  = 1'b0;
               end
            end
            default: state_d[p] = ST_IDLE;
         endcase
      end
      // The granted SRAM was unbound in bound_q, so this never collides with a release above.
      if (grant) begin
         bound_d[sram_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p] <= ST_IDLE;
            bind_q[p]  <= '0;
         end
         bound_q <= '0;
         rr_q    <= '0;
         gvld_q  <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            state_q[p] <= state_d[p];
            bind_q[p]  <= bind_d[p];
         end
         bound_q <= bound_d;
         rr_q    <= rr_d;
         gvld_q  <= gvld_d;
      end
   end

`ifdef ALLOC_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_q[p] <= '0;
         end
         fail_q <= '0;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            cnt_q[p] <= cnt_d[p];
         end
         fail_q <= fail_d;
      end
   end

   assign grant_fail_o = fail_q;
`else
   assign grant_fail_o = '0;
`endif

   always_comb begin
      grant_sram_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         grant_sram_o[p*SRAM_IDX_W +: SRAM_IDX_W] = bind_q[p];
      end
   end

   assign grant_vld_o  = gvld_q;
   assign sram_bound_o = bound_q;

endmodule

// File: tb/tb_sram_alloc_arbiter.sv
// Directed bench for sram_alloc_arbiter: cycle vector table plus reset, round-robin wrap and timeout sequences.
module tb_sram_alloc_arbiter;
   import sram_alloc_arbiter_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                            rst;
   logic [NUM_PORTS-1:0]            req_vld, rel, gvld, gfail;
   logic [NUM_PORTS*LEN_W-1:0]      req_len;
   logic [NUM_SRAMS*PAGE_CNT_W-1:0] free_space;
   logic [NUM_PORTS*SRAM_IDX_W-1:0] gsram;
   logic [NUM_SRAMS-1:0]            bound;

   int n_pass  = 0;
   int n_total = 0;

   sram_alloc_arbiter dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req_vld_i    (req_vld),
      .req_len_i    (req_len),
      .release_i    (rel),
      .free_space_i (free_space),
      .grant_vld_o  (gvld),
      .grant_sram_o (gsram),
      .sram_bound_o (bound),
      .grant_fail_o (gfail)
   );

   typedef struct {
      logic [15:0] req;
      logic [15:0] rls;
      int          len;
      int          mode;
      logic [15:0] exp_gvld;
      logic [31:0] exp_bound;
      int          chk_port;
      int          exp_gsram;
   } vec_t;

   vec_t vecs [25];

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // 0: all 2047; 1: SRAM0..6 =1000, rest 2047; 2: all 100, SRAM2 =5; 3: all 0; 4: SRAM4 =50, SRAM9 =60, rest 0
   function automatic logic [NUM_SRAMS*PAGE_CNT_W-1:0] fs_pat(input int mode);
      logic [NUM_SRAMS*PAGE_CNT_W-1:0] v;
      v = '0;
      for (int s = 0; s < NUM_SRAMS; s++) begin
         logic [PAGE_CNT_W-1:0] f;
         case (mode)
            0:       f = 11'd2047;
            1:       f = (s < 7) ? 11'd1000 : 11'd2047;
            2:       f = (s == 2) ? 11'd5 : 11'd100;
            3:       f = 11'd0;
            default: f = (s == 4) ? 11'd50 : ((s == 9) ? 11'd60 : 11'd0);
         endcase
         v[s*PAGE_CNT_W +: PAGE_CNT_W] = f;
      end
      return v;
   endfunction

   function automatic logic [NUM_PORTS*LEN_W-1:0] len_all(input int l);
      logic [LEN_W-1:0] one;
      one = LEN_W'(l);
      return {NUM_PORTS{one}};
   endfunction

   function automatic logic [SRAM_IDX_W-1:0] gs(input int p);
      return gsram[p*SRAM_IDX_W +: SRAM_IDX_W];
   endfunction

   initial begin
      int first_fail;
      int n_fail_pulse;
      int n_gnt;

      //             req      rel      len mode gvld     bound          port gsram
      vecs[0]  = '{16'h0008, 16'h0000, 4, 1, 16'h0000, 32'h0000_0000, 3,  0};
      vecs[1]  = '{16'h0008, 16'h0000, 4, 1, 16'h0008, 32'h0000_0080, 3,  7};
      vecs[2]  = '{16'h0000, 16'h0000, 4, 1, 16'h0000, 32'h0000_0080, 3,  7};
      vecs[3]  = '{16'h0000, 16'h0008, 4, 1, 16'h0000, 32'h0000_0000, 3,  0};
      vecs[4]  = '{16'h0001, 16'h0000, 5, 2, 16'h0000, 32'h0000_0000, 0,  0};
      vecs[5]  = '{16'h0001, 16'h0000, 5, 2, 16'h0001, 32'h0000_0001, 0,  0};
      vecs[6]  = '{16'h0000, 16'h0001, 5, 2, 16'h0000, 32'h0000_0000, 0,  0};
      vecs[7]  = '{16'h8021, 16'h0000, 0, 1, 16'h0000, 32'h0000_0000, 5,  0};
      vecs[8]  = '{16'h8021, 16'h0000, 0, 1, 16'h0020, 32'h0000_0080, 5,  7};
      vecs[9]  = '{16'h8021, 16'h0000, 0, 1, 16'h8000, 32'h0000_0180, 15, 8};
      vecs[10] = '{16'h8021, 16'h0000, 0, 1, 16'h0001, 32'h0000_0380, 0,  9};
      vecs[11] = '{16'h0000, 16'h8021, 0, 1, 16'h0000, 32'h0000_0000, 15, 0};
      vecs[12] = '{16'h0004, 16'h0000, 0, 1, 16'h0000, 32'h0000_0000, 2,  0};
      vecs[13] = '{16'h0000, 16'h0000, 0, 1, 16'h0000, 32'h0000_0000, 2,  0};
      vecs[14] = '{16'h0000, 16'h0000, 0, 1, 16'h0000, 32'h0000_0000, 2,  0};
      vecs[15] = '{16'h0004, 16'h0000, 0, 1, 16'h0000, 32'h0000_0000, 2,  0};
      vecs[16] = '{16'h0004, 16'h0004, 0, 1, 16'h0000, 32'h0000_0000, 2,  0};
      vecs[17] = '{16'h0000, 16'h0000, 0, 1, 16'h0000, 32'h0000_0000, 2,  0};
      vecs[18] = '{16'h000E, 16'h0000, 9, 4, 16'h0000, 32'h0000_0000, 1,  0};
      vecs[19] = '{16'h000E, 16'h0000, 9, 4, 16'h0002, 32'h0000_0200, 1,  9};
      vecs[20] = '{16'h000E, 16'h0000, 9, 4, 16'h0004, 32'h0000_0210, 2,  4};
      vecs[21] = '{16'h000E, 16'h0000, 9, 4, 16'h0000, 32'h0000_0210, 3,  0};
      vecs[22] = '{16'h000C, 16'h0002, 9, 4, 16'h0000, 32'h0000_0010, 1,  0};
      vecs[23] = '{16'h000C, 16'h0000, 9, 4, 16'h0008, 32'h0000_0210, 3,  9};
      vecs[24] = '{16'h0000, 16'h000C, 9, 4, 16'h0000, 32'h0000_0000, 3,  0};

      rst        = 1'b1;
      req_vld    = '0;
      rel        = '0;
      req_len    = '0;
      free_space = '0;
      tick();
      tick();
      check("reset gvld",  128'(gvld),  128'(0));
      check("reset bound", 128'(bound), 128'(0));
      check("reset gsram", 128'(gsram), 128'(0));
      check("reset gfail", 128'(gfail), 128'(0));
      rst = 1'b0;

      for (int i = 0; i < 25; i++) begin
         req_vld    = vecs[i].req;
         rel        = vecs[i].rls;
         req_len    = len_all(vecs[i].len);
         free_space = fs_pat(vecs[i].mode);
         tick();
         check($sformatf("v%0d gvld", i),  128'(gvld),  128'(vecs[i].exp_gvld));
         check($sformatf("v%0d bound", i), 128'(bound), 128'(vecs[i].exp_bound));
         check($sformatf("v%0d gsram[%0d]", i, vecs[i].chk_port),
               128'(gs(vecs[i].chk_port)), 128'(vecs[i].exp_gsram));
         check($sformatf("v%0d gfail", i), 128'(gfail), 128'(0));
      end
      req_vld = '0;
      rel     = '0;

      // Reset in the middle of a bound packet; rr_ptr is 4 before this.
      req_vld    = 16'h0040;
      req_len    = len_all(0);
      free_space = fs_pat(0);
      tick();
      tick();
      check("midrst grant", 128'(gvld),  128'(16'h0040));
      check("midrst bound", 128'(bound), 128'(32'h1));
      rst     = 1'b1;
      req_vld = '0;
      tick();
      check("midrst bound clr", 128'(bound), 128'(0));
      check("midrst gsram clr", 128'(gsram), 128'(0));
      check("midrst gvld clr",  128'(gvld),  128'(0));
      rst = 1'b0;

      // Round robin from rr_ptr=0, then confirm the pointer wrapped back to 0.
      req_vld    = 16'h8021;
      free_space = fs_pat(1);
      tick();
      tick();
      check("rr g0",    128'(gvld), 128'(16'h0001));
      check("rr g0 sr", 128'(gs(0)), 128'(7));
      tick();
      check("rr g5",    128'(gvld), 128'(16'h0020));
      check("rr g5 sr", 128'(gs(5)), 128'(8));
      tick();
      check("rr g15",    128'(gvld), 128'(16'h8000));
      check("rr g15 sr", 128'(gs(15)), 128'(9));
      req_vld = '0;
      rel     = 16'h8021;
      tick();
      rel     = '0;
      req_vld = 16'h0009;
      tick();
      tick();
      check("rr wrap", 128'(gvld), 128'(16'h0001));
      tick();
      check("rr next", 128'(gvld), 128'(16'h0008));
      req_vld = '0;
      rel     = 16'h0009;
      tick();
      rel = '0;
      check("rr rel bound", 128'(bound), 128'(0));

      // Starved port: no SRAM ever fits.
      req_vld    = 16'h0002;
      req_len    = len_all(0);
      free_space = fs_pat(3);
      tick();
      first_fail   = -1;
      n_fail_pulse = 0;
      n_gnt        = 0;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (gfail != '0) begin
            n_fail_pulse++;
            if (first_fail < 0) first_fail = k;
            req_vld = '0;
         end
         if (gvld != '0) n_gnt++;
      end
      check("starve no grant", 128'(n_gnt), 128'(0));
`ifdef ALLOC_TIMEOUT_EN
      check("timeout cycle",  128'(first_fail),   128'(256));
      check("timeout pulses", 128'(n_fail_pulse), 128'(1));
      free_space = fs_pat(0);
      n_gnt = 0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (gvld != '0) n_gnt++;
      end
      check("timeout idle", 128'(n_gnt), 128'(0));
`else
      check("no timeout", 128'(n_fail_pulse), 128'(0));
      free_space = fs_pat(0);
      tick();
      check("late grant",    128'(gvld),  128'(16'h0002));
      check("late grant sr", 128'(gs(1)), 128'(0));
      req_vld = '0;
      rel     = 16'h0002;
      tick();
      rel = '0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
